// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-word layout and ID/EX payload bundle
//   CW_WIDTH       control-word width
//   CW_*           bit positions inside the control word
//   DATA_WIDTH     PC+4 / operand / immediate width
//   REG_ADDR_WIDTH register-number width
//   id_ex_payload_t  non-control fields carried from ID to EX
package pipe_pkg;
  localparam int CW_WIDTH       = 11;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CW_REGDST      = 10;
  localparam int CW_BRANCH_HI   = 9;
  localparam int CW_BRANCH_LO   = 8;
  localparam int CW_MEMREAD     = 7;
  localparam int CW_MEMTOREG    = 6;
  localparam int CW_ALUOP_HI    = 5;
  localparam int CW_ALUOP_LO    = 3;
  localparam int CW_MEMWRITE    = 2;
  localparam int CW_ALUSRC      = 1;
  localparam int CW_REGWRITE    = 0;
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [DATA_WIDTH-1:0]     read_data1;
    logic [DATA_WIDTH-1:0]     read_data2;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } id_ex_payload_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
//   clk, reset   clock and async active-high reset
//   clear        synchronous clear, wins over inc
//   inc          count up by one unless already all-ones
//   count        current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = clear ? '0 : (inc && count_q != '1) ? count_q + WIDTH'(1) : count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall hold, flush bubble and perf counters
//   clk, reset        clock and async active-high reset
//   stall, flush      hold contents / load a bubble (stall wins)
//   perf_clear        synchronous clear of both counters
//   ID_*              control word and payload from ID
//   EX_*              registered control word and payload, EX_valid marks a real instruction
//   EX_mem_read, EX_reg_write, EX_write_reg  decoded for hazard/forwarding units
//   stall_count, bubble_count  saturating performance counters
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH     = pipe_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = pipe_pkg::REG_ADDR_WIDTH,
  parameter int CW_WIDTH       = pipe_pkg::CW_WIDTH,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      perf_clear,
  input  logic [CW_WIDTH-1:0]       ID_control_words,
  input  logic [DATA_WIDTH-1:0]     ID_pc_plus4,
  input  logic [DATA_WIDTH-1:0]     ID_read_data1,
  input  logic [DATA_WIDTH-1:0]     ID_read_data2,
  input  logic [DATA_WIDTH-1:0]     ID_imm_ext,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rs,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rt,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rd,
  output logic [CW_WIDTH-1:0]       EX_control_words,
  output logic [DATA_WIDTH-1:0]     EX_pc_plus4,
  output logic [DATA_WIDTH-1:0]     EX_read_data1,
  output logic [DATA_WIDTH-1:0]     EX_read_data2,
  output logic [DATA_WIDTH-1:0]     EX_imm_ext,
  output logic [REG_ADDR_WIDTH-1:0] EX_rs,
  output logic [REG_ADDR_WIDTH-1:0] EX_rt,
  output logic [REG_ADDR_WIDTH-1:0] EX_rd,
  output logic                      EX_valid,
  output logic                      EX_mem_read,
  output logic                      EX_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] EX_write_reg,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      bubble_count
);
  import pipe_pkg::*;
  logic [CW_WIDTH-1:0] cw_q, cw_d;
  id_ex_payload_t      pl_q, pl_d, id_pl;
  logic                valid_q, valid_d;
  always_comb begin
    id_pl            = '0;
    id_pl.pc_plus4   = ID_pc_plus4;
    id_pl.read_data1 = ID_read_data1;
    id_pl.read_data2 = ID_read_data2;
    id_pl.imm_ext    = ID_imm_ext;
    id_pl.rs         = ID_rs;
    id_pl.rt         = ID_rt;
    id_pl.rd         = ID_rd;
  end
  // stall freezes everything, so a flush in a stalled cycle is dropped
  always_comb begin
    cw_d    = stall ? cw_q : flush ? '0 : ID_control_words;
    pl_d    = stall ? pl_q : flush ? '0 : id_pl;
    valid_d = stall ? valid_q : !flush;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cw_q    <= '0;
      pl_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      cw_q    <= cw_d;
      pl_q    <= pl_d;
      valid_q <= valid_d;
    end
  assign EX_control_words = cw_q;
  assign EX_pc_plus4      = pl_q.pc_plus4;
  assign EX_read_data1    = pl_q.read_data1;
  assign EX_read_data2    = pl_q.read_data2;
  assign EX_imm_ext       = pl_q.imm_ext;
  assign EX_rs            = pl_q.rs;
  assign EX_rt            = pl_q.rt;
  assign EX_rd            = pl_q.rd;
  assign EX_valid         = valid_q;
  assign EX_mem_read      = cw_q[CW_MEMREAD];
  // a bubble must never look like a register write to forwarding logic
  assign EX_reg_write     = cw_q[CW_REGWRITE] & valid_q;
  assign EX_write_reg     = cw_q[CW_REGDST] ? pl_q.rd : pl_q.rt;
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (perf_clear),
    .inc   (stall),
    .count (stall_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (perf_clear),
    .inc   (!stall && flush),
    .count (bubble_count)
  );
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: scoreboard bench for id_ex_pipe_reg with 4-bit counters
module tb_id_ex_pipe_reg;
  localparam int CW = 11, DW = 32, AW = 5, CN = 4;
  localparam int VW = CW + 4*DW + 3*AW + 3 + AW + 2*CN;
  logic clk = 0, reset = 1, stall = 0, flush = 0, perf_clear = 0;
  logic [CW-1:0] id_cw = '0;
  logic [DW-1:0] id_pc = '0, id_d1 = '0, id_d2 = '0, id_imm = '0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [CW-1:0] ex_cw;
  logic [DW-1:0] ex_pc, ex_d1, ex_d2, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd, ex_wr;
  logic ex_valid, ex_mr, ex_rw;
  logic [CN-1:0] sc, bc;
  logic [VW-1:0] obs;
  logic [CW-1:0] m_cw;
  logic [DW-1:0] m_pc, m_d1, m_d2, m_imm;
  logic [AW-1:0] m_rs, m_rt, m_rd;
  logic m_v;
  logic [CN-1:0] m_sc, m_bc;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] e;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  id_ex_pipe_reg #(.CNT_WIDTH(CN)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .perf_clear(perf_clear),
    .ID_control_words(id_cw), .ID_pc_plus4(id_pc), .ID_read_data1(id_d1),
    .ID_read_data2(id_d2), .ID_imm_ext(id_imm), .ID_rs(id_rs), .ID_rt(id_rt), .ID_rd(id_rd),
    .EX_control_words(ex_cw), .EX_pc_plus4(ex_pc), .EX_read_data1(ex_d1),
    .EX_read_data2(ex_d2), .EX_imm_ext(ex_imm), .EX_rs(ex_rs), .EX_rt(ex_rt), .EX_rd(ex_rd),
    .EX_valid(ex_valid), .EX_mem_read(ex_mr), .EX_reg_write(ex_rw), .EX_write_reg(ex_wr),
    .stall_count(sc), .bubble_count(bc)
  );
  assign obs = {ex_cw, ex_pc, ex_d1, ex_d2, ex_imm, ex_rs, ex_rt, ex_rd,
                ex_valid, ex_mr, ex_rw, ex_wr, sc, bc};
  function automatic logic [VW-1:0] model_vec();
    return {m_cw, m_pc, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd,
            m_v, m_cw[7], m_cw[0] & m_v, m_cw[10] ? m_rd : m_rt, m_sc, m_bc};
  endfunction
  task automatic model_reset();
    {m_cw, m_pc, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd, m_v, m_sc, m_bc} = '0;
  endtask
  task automatic set_id(input logic [CW-1:0] cw, input logic [DW-1:0] pc, d1, d2, imm,
                        input logic [AW-1:0] rs, rt, rd);
    id_cw = cw; id_pc = pc; id_d1 = d1; id_d2 = d2; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd;
  endtask
  // model the coming edge, queue its expectation, then step to 1 unit after it
  task automatic advance();
    if (!stall) begin
      if (flush) {m_cw, m_pc, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd, m_v} = '0;
      else begin
        {m_cw, m_pc, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd} =
          {id_cw, id_pc, id_d1, id_d2, id_imm, id_rs, id_rt, id_rd};
        m_v = 1'b1;
      end
    end
    m_sc = perf_clear ? '0 : (stall && m_sc != '1) ? m_sc + 1'b1 : m_sc;
    m_bc = perf_clear ? '0 : (!stall && flush && m_bc != '1) ? m_bc + 1'b1 : m_bc;
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    model_reset();
    #3;
    exp_q.push_back(model_vec());
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_init got %h want %h", obs, e); end
    @(negedge clk);
    reset = 0;
    set_id(11'h4C1, 32'h0000_0010, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3);
    advance();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_preload got %h want %h", obs, e); end
    #3;
    reset = 1;
    model_reset();
    exp_q.push_back(model_vec());
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_async got %h want %h", obs, e); end
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    reset = 0;
  endtask
  task automatic test_load();
    set_id(11'h401, 32'h0000_0014, 32'hA5A5_0001, 32'h0000_0022, 32'hFFFF_FFF0, 5'd7, 5'd3, 5'd8);
    advance();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL load got %h want %h", obs, e); end
    checks++;
    if ({ex_cw, ex_wr, ex_rw, ex_valid} !== {11'h401, 5'd8, 1'b1, 1'b1}) begin
      errors++; $display("FAIL load_fields got cw=%h wr=%0d rw=%b v=%b want 401 8 1 1", ex_cw, ex_wr, ex_rw, ex_valid);
    end
    set_id(11'h0C1, 32'h0000_0018, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0004, 5'd9, 5'd10, 5'd11);
    advance();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL load_rt got %h want %h", obs, e); end
    checks++;
    if ({ex_wr, ex_mr} !== {5'd10, 1'b1}) begin
      errors++; $display("FAIL load_rt_dec got wr=%0d mr=%b want 10 1", ex_wr, ex_mr);
    end
  endtask
  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(11'(12'h7FF - i), $urandom, $urandom, $urandom, $urandom, 5'(i), 5'(i + 1), 5'(i + 2));
      advance();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL stall_%0d got %h want %h", i, obs, e); end
    end
    checks++;
    if (sc !== 4'd3 || ex_cw !== 11'h0C1) begin
      errors++; $display("FAIL stall_count got sc=%0d cw=%h want 3 0c1", sc, ex_cw);
    end
    stall = 0;
  endtask
  task automatic test_flush();
    flush = 1;
    set_id(11'h0C1, 32'h40, 32'h41, 32'h42, 32'h43, 5'd4, 5'd5, 5'd6);
    advance();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL flush got %h want %h", obs, e); end
    checks++;
    if ({ex_cw, ex_valid, ex_rw, bc} !== {11'h0, 1'b0, 1'b0, 4'd1}) begin
      errors++; $display("FAIL flush_fields got cw=%h v=%b rw=%b bc=%0d want 0 0 0 1", ex_cw, ex_valid, ex_rw, bc);
    end
    flush = 0;
    advance();
    void'(exp_q.pop_front());
    stall = 1;
    flush = 1;
    set_id(11'h3FF, 32'h50, 32'h51, 32'h52, 32'h53, 5'd7, 5'd8, 5'd9);
    advance();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL flush_stalled got %h want %h", obs, e); end
    checks++;
    if (bc !== 4'd1 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL flush_stalled_bc got bc=%0d v=%b want 1 1", bc, ex_valid);
    end
    stall = 0;
    flush = 0;
  endtask
  task automatic test_saturation();
    stall = 1;
    for (int i = 0; i < 20; i++) begin
      advance();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL sat_%0d got %h want %h", i, obs, e); end
    end
    checks++;
    if (sc !== 4'hF) begin errors++; $display("FAIL sat_value got %h want f", sc); end
    perf_clear = 1;
    advance();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || sc !== 4'd0) begin errors++; $display("FAIL clear got %h want %h", obs, e); end
    perf_clear = 0;
    advance();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || sc !== 4'd1) begin errors++; $display("FAIL clear_then_inc got %h want %h", obs, e); end
    stall = 0;
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 3) == 0);
      perf_clear = ($urandom_range(0, 15) == 0);
      set_id(11'($urandom), $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      advance();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        if (obs !== e) begin errors++; $display("FAIL back_to_back_final got %h want %h", obs, e); end
      end
    end
    stall = 0; flush = 0; perf_clear = 0;
    for (int i = 0; i < 8; i++) begin
      set_id(11'($urandom), $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      advance();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL back_to_back_%0d got %h want %h", i, obs, e); end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register, directly downstream of the ID-stage control-word flush logic.
- Captures the ID-stage control word and operands each cycle and presents them to EX.
- Holds its contents on an EX stall and inserts a bubble (zero control word, valid=0) on flush.
- Keeps saturating performance counters for stall cycles and inserted bubbles.

Parameters:
- DATA_WIDTH, 32, width of PC+4, register operands and extended immediate
- REG_ADDR_WIDTH, 5, register-number width
- CW_WIDTH, 11, control-word width
- CNT_WIDTH, 16, performance-counter width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous active-high reset
- stall  input  1  hold ID/EX contents this cycle (EX not ready)
- flush  input  1  load a bubble instead of the ID instruction
- perf_clear  input  1  synchronous clear of both counters
- ID_control_words  input  CW_WIDTH  control word from ID (already zeroed upstream on ID flush)
- ID_pc_plus4  input  DATA_WIDTH  PC+4 of ID instruction
- ID_read_data1, ID_read_data2  input  DATA_WIDTH  register-file operands
- ID_imm_ext  input  DATA_WIDTH  sign/zero-extended immediate
- ID_rs, ID_rt, ID_rd  input  REG_ADDR_WIDTH  register numbers
- EX_control_words  output  CW_WIDTH  registered control word
- EX_pc_plus4, EX_read_data1, EX_read_data2, EX_imm_ext  output  DATA_WIDTH  registered payload
- EX_rs, EX_rt, EX_rd  output  REG_ADDR_WIDTH  registered register numbers
- EX_valid  output  1  1 = real instruction in EX, 0 = bubble
- EX_mem_read, EX_reg_write  output  1  decoded from EX_control_words, for the hazard/forwarding units
- EX_write_reg  output  REG_ADDR_WIDTH  EX_rd if RegDst else EX_rt
- stall_count, bubble_count  output  CNT_WIDTH  performance counters

Behaviour:
- Reset (async, active-high): every registered output and both counters go to 0, and EX_valid=0. Clock edges are ignored while reset is high. Reset asserted mid-stall discards the held instruction.
- Per-edge priority for the pipe register: reset > stall > flush > load.
  - stall=1: all EX_* registers hold, including EX_valid. A flush asserted in the same cycle is ignored; upstream re-asserts it if still required.
  - stall=0, flush=1: EX_control_words=0, all payload fields=0, EX_valid=0.
  - stall=0, flush=0: all ID_* inputs are captured and EX_valid=1.
- Latency is exactly 1 cycle from ID inputs to EX outputs; there is no combinational path from ID to EX.
- Control-word layout, fixed in the package:
  - [10] RegDst
  - [9:8] Branch ([9]=branch, [8]=1 beq / 0 bne)
  - [7] MemRead
  - [6] MemtoReg
  - [5:3] ALUop
  - [2] MemWrite
  - [1] ALUSrc
  - [0] RegWrite
  - Jump and SignZero are consumed in ID and not carried.
- Decoded outputs are combinational from the registers:
  - EX_mem_read=cw[7]
  - EX_reg_write=cw[0] & EX_valid
  - EX_write_reg=cw[10] ? EX_rd : EX_rt
- Counters, per edge, with priority reset > perf_clear > increment:
  - stall_count +1 on every cycle with stall=1.
  - bubble_count +1 on every cycle with stall=0 and flush=1.
  - Both saturate at all-ones and never wrap.
  - perf_clear together with an increment condition: the result is 0.

Decomposition:
- Package pipe_pkg holds:
  - CW_WIDTH
  - bit-index localparams CW_REGDST, CW_BRANCH_HI/LO, CW_MEMREAD, CW_MEMTOREG, CW_ALUOP_HI/LO, CW_MEMWRITE, CW_ALUSRC, CW_REGWRITE
  - a packed struct typedef id_ex_payload_t bundling pc_plus4, read_data1/2, imm_ext, rs, rt, rd
- One sub-module, sat_counter (parameter WIDTH; inputs clk, reset, clear, inc; output count), instantiated twice.

Test Plan:
- Reset mid-stream: load cw=11'h4C1, pc=32'h0000_0010, then assert reset asynchronously between edges -> all outputs 0 immediately, without waiting for an edge, and EX_valid=0.
- Load: ID cw=11'h401, rd=5'd8, rt=5'd3, data1=32'hA5A5_0001 -> next edge EX_control_words=11'h401, EX_write_reg=8, EX_reg_write=1, EX_valid=1.
- Stall 3 cycles with changing ID inputs -> EX outputs frozen at the prior value and stall_count=3.
- Flush with stall=0 and ID cw=11'h0C1 -> EX_control_words=0, EX_valid=0, EX_reg_write=0, bubble_count=1. Flush with stall=1 -> outputs hold and bubble_count is unchanged.
- Saturation: CNT_WIDTH=4 with 20 stall cycles -> stall_count=4'hF. Then perf_clear together with stall -> 0 next edge, then 1 on the following stall cycle.
